// File: rtl/seg_pkg.sv
// Shared 7-segment constants for the scan counter and its decoder.
// Segment order is {g,f,e,d,c,b,a}; the decimal point occupies bit SEG_DP of seg_data.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_DP = 7;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder.
// Codes 10..15 produce a dark digit.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_counter.sv
// N-digit BCD up/down counter with a multiplexed 7-segment scan driver.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk_1k,
    input  logic                  reset,
    input  logic                  cnt_en,
    input  logic                  cnt_up,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic [N_DIGITS-1:0]   seg_com,
    output logic [7:0]            seg_data,
    output logic [4*N_DIGITS-1:0] value
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [TW-1:0]         tick_cnt;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic                  tick;
    logic                  scan_wrap;
    logic [4*N_DIGITS-1:0] value_next;
    logic [N_DIGITS:0]     chain;
    logic [3:0]            cur_digit;
    logic [3:0]            sel_digit;
    logic                  sel_dp;
    logic [3:0]            dec_in;
    logic [6:0]            seg;
    logic [7:0]            seg_data_next;

    assign tick      = cnt_en && (tick_cnt == TW'(TICK_DIV - 1));
    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

    // Ripple carry (up) or borrow (down) through the digits; chain[0] is the step itself.
    always_comb begin
        value_next = value;
        chain      = '0;
        chain[0]   = 1'b1;
        cur_digit  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            cur_digit = value[4*i +: 4];
            if (chain[i]) begin
                if (cnt_up) begin
                    if (cur_digit >= 4'd9) begin
                        value_next[4*i +: 4] = 4'd0;
                        chain[i+1]           = 1'b1;
                    end else begin
                        value_next[4*i +: 4] = cur_digit + 4'd1;
                    end
                end else begin
                    if (cur_digit == 4'd0 || cur_digit > 4'd9) begin
                        value_next[4*i +: 4] = 4'd9;
                        chain[i+1]           = 1'b1;
                    end else begin
                        value_next[4*i +: 4] = cur_digit - 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                sel_digit = value[4*i +: 4];
                sel_dp    = dp_mask[i];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic [N_DIGITS:0] upper_zero;
    logic              sel_blank;

    // upper_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        upper_zero           = '0;
        upper_zero[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (value[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        sel_blank = 1'b0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                sel_blank = upper_zero[i];
            end
        end
    end

    assign dec_in = sel_blank ? 4'hF : sel_digit;
`else
    assign dec_in = sel_digit;
`endif

    bcd_to_seg u_dec (
        .bcd (dec_in),
        .seg (seg)
    );

    always_comb begin
        seg_data_next         = {1'b0, seg};
        seg_data_next[SEG_DP] = sel_dp;
    end

    always_ff @(posedge clk_1k) begin
        if (reset) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
            value    <= '0;
            seg_com  <= '1;
            seg_data <= 8'h00;
        end else begin
            if (cnt_en) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end
            if (tick) begin
                value <= value_next;
            end
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) begin
                scan_idx <= (scan_idx == IW'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end
            seg_com  <= ~(N_DIGITS'(1) << scan_idx);
            seg_data <= seg_data_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Scoreboard bench for seg_scan_counter (N_DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
// A decimal behavioural model queues the expected outputs of every cycle.
module tb_seg_scan_counter;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk_1k = 1'b0;
    logic        reset;
    logic        cnt_en;
    logic        cnt_up;
    logic [3:0]  dp_mask;
    logic [3:0]  seg_com;
    logic [7:0]  seg_data;
    logic [15:0] value;

    typedef struct {
        logic [3:0]  com;
        logic [7:0]  data;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_val, m_pre, m_spre, m_idx;

    seg_scan_counter #(.N_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk_1k   (clk_1k),
        .reset    (reset),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .dp_mask  (dp_mask),
        .seg_com  (seg_com),
        .seg_data (seg_data),
        .value    (value)
    );

    always #5 clk_1k = ~clk_1k;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int p10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic up, input logic [3:0] dp);
        exp_t e;
        int   d;
        reset   = r;
        cnt_en  = en;
        cnt_up  = up;
        dp_mask = dp;
        if (r) begin
            e.com  = 4'hF;
            e.data = 8'h00;
            m_val  = 0;
            m_pre  = 0;
            m_spre = 0;
            m_idx  = 0;
        end else begin
            e.com  = ~(4'b0001 << m_idx);
            d      = (m_val / p10(m_idx)) % 10;
            e.data = {dp[m_idx], seg7(d)};
`ifdef SEG_SCAN_LZB_EN
            if (m_idx > 0 && m_val < p10(m_idx)) e.data[6:0] = 7'h00;
`endif
            if (en) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_val = up ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
                end else begin
                    m_pre++;
                end
            end
            if (m_spre == SD - 1) begin
                m_spre = 0;
                m_idx  = (m_idx + 1) % ND;
            end else begin
                m_spre++;
            end
        end
        e.val = to_bcd(m_val);
        sb.push_back(e);
        @(posedge clk_1k);
        #1;
        e = sb.pop_front();
        chk("seg_com", 32'(seg_com), 32'(e.com));
        chk("seg_data", 32'(seg_data), 32'(e.data));
        chk("value", 32'(value), 32'(e.val));
    endtask

    initial begin
        reset = 1'b1; cnt_en = 1'b0; cnt_up = 1'b1; dp_mask = '0;

        // Idle scan with counting disabled, then a decimal point on digit 2
        step(1, 0, 1, 4'b0000);
        step(1, 0, 1, 4'b0000);
        chk("reset_com", 32'(seg_com), 32'h0000000F);
        step(0, 0, 1, 4'b0000);
        chk("first_digit", 32'(seg_com), 32'h0000000E);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 4'b0000);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 4'b0100);

        // Count up 10 ticks: carry into digit 1
        step(1, 0, 1, 4'b0000);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 4'b0000);
        chk("val_0010", 32'(value), 32'h00000010);

        // Pause for 3 cycles at prescaler 2
        step(1, 0, 1, 4'b0000);
        step(0, 1, 1, 4'b0000);
        step(0, 1, 1, 4'b0000);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b0000);
        step(0, 1, 1, 4'b0000);
        chk("pause_hold", 32'(value), 32'h00000000);
        step(0, 1, 1, 4'b0000);
        chk("pause_tick", 32'(value), 32'h00000001);

        // Down wrap 0000 -> 9999, then up wrap back to 0000
        step(1, 0, 1, 4'b0000);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 4'b1010);
        chk("wrap_9999", 32'(value), 32'h00009999);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 4'b1010);
        chk("wrap_0000", 32'(value), 32'h00000000);

        // Count to 0123, then reset mid-scan
        step(1, 0, 1, 4'b0000);
        for (int i = 0; i < 123 * TD; i++) step(0, 1, 1, 4'($urandom_range(0, 15)));
        chk("val_0123", 32'(value), 32'h00000123);
        step(0, 1, 1, 4'b0000);
        step(1, 1, 1, 4'b1111);
        chk("midreset_com", 32'(seg_com), 32'h0000000F);
        chk("midreset_val", 32'(value), 32'h00000000);
        step(0, 0, 1, 4'b0000);
        chk("restart_com", 32'(seg_com), 32'h0000000E);

        // Random direction / enable changes between ticks
        for (int i = 0; i < 200; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
